// File: rtl/alu_result_display_pkg.sv
// ---------------------------------------------------------------------------
// alu_result_display_pkg
//   Shared definitions for the ALU result display: the display FSM state
//   encoding, the fixed segment patterns and the default timing parameters.
//   No ports; imported with `import alu_result_display_pkg::*;`.
// ---------------------------------------------------------------------------
package alu_result_display_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHOW_HI,
        GAP_HI,
        SHOW_LO,
        GAP_LO
    } disp_state_t;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int DEF_PRESCALE = 1000;
    localparam int DEF_DWELL    = 4;

endpackage

// File: rtl/alu_result_display_hex_to_seg7.sv
// ---------------------------------------------------------------------------
// hex_to_seg7
//   Combinational hex digit to seven-segment glyph decoder. Shared with the
//   upstream ALU top, so it stays free of any display-sequencing logic.
//   Ports:
//     nibble_i  in   4  hex digit 0..F
//     seg_o     out  7  segments {g,f,e,d,c,b,a}, active-high
// ---------------------------------------------------------------------------
module hex_to_seg7 (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        unique case (nibble_i)
            4'h0: seg_o = 7'h3F;
            4'h1: seg_o = 7'h06;
            4'h2: seg_o = 7'h5B;
            4'h3: seg_o = 7'h4F;
            4'h4: seg_o = 7'h66;
            4'h5: seg_o = 7'h6D;
            4'h6: seg_o = 7'h7D;
            4'h7: seg_o = 7'h07;
            4'h8: seg_o = 7'h7F;
            4'h9: seg_o = 7'h6F;
            4'hA: seg_o = 7'h77;
            4'hB: seg_o = 7'h7C;
            4'hC: seg_o = 7'h39;
            4'hD: seg_o = 7'h5E;
            4'hE: seg_o = 7'h79;
            default: seg_o = 7'h71;
        endcase
    end

endmodule

// File: rtl/alu_result_display.sv
// ---------------------------------------------------------------------------
// alu_result_display
//   Shows an 8-bit ALU result on one seven-segment digit as a timed sequence:
//   high nibble, blank, low nibble, blank, then a dash while idle. Results
//   arriving mid-sequence wait in a one-entry buffer (newest wins).
//   Parameters:
//     PRESCALE  clk cycles per display tick (2..65535)
//     DWELL     ticks per display phase     (1..255)
//   Ports:
//     clk           in   1  system clock
//     rst_n         in   1  asynchronous active-low reset
//     ena           in   1  enable; low freezes all state
//     result        in   8  ALU sum to display
//     result_valid  in   1  single-cycle strobe qualifying result/carry
//     carry         in   1  ALU carry-out
//     seg_out       out  7  registered segments {g,f,e,d,c,b,a}
//     dp_out        out  1  registered decimal point
//     busy          out  1  high whenever the FSM is not IDLE
//   Build option:
//     DISP_CARRY_EN  when defined, dp_out shows the captured carry during the
//                    two SHOW phases; otherwise dp_out is tied low.
// ---------------------------------------------------------------------------
module alu_result_display
    import alu_result_display_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int DWELL    = DEF_DWELL
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] result,
    input  logic       result_valid,
    input  logic       carry,
    output logic [6:0] seg_out,
    output logic       dp_out,
    output logic       busy
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);
    localparam logic [7:0]  DWELL_LAST = 8'(DWELL - 1);

    disp_state_t state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [7:0]  dwell_q, dwell_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  pend_q, pend_d;
    logic        pend_full_q, pend_full_d;
    logic [6:0]  seg_q, seg_d;
    logic        armed_q;

    logic        tick, phase_end, lo_exit;
    logic        load_new, load_pend, store_pend;
    logic        show_d;
    logic [3:0]  nibble_d;
    logic [6:0]  glyph_d;

    // Reset release is taken through armed_q so the first capture lands on
    // the second clk edge after rst_n rises; the first edge only arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
        end else if (ena) begin
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        tick       = (presc_q == PRESC_LAST);
        phase_end  = tick && (dwell_q == DWELL_LAST);
        lo_exit    = (state_q == GAP_LO) && phase_end;
        // A strobe on the GAP_LO exit cycle goes straight to the display and
        // supersedes whatever is pending.
        load_new   = result_valid && (((state_q == IDLE) && armed_q) || lo_exit);
        load_pend  = lo_exit && !result_valid && pend_full_q;
        store_pend = result_valid && (state_q != IDLE) && !lo_exit;

        // NOTE: every combinational output gets a default first, so no path
        // through the case statements leaves a latch behind.
        state_d     = state_q;
        presc_d     = 16'd0;
        dwell_d     = 8'd0;
        data_d      = load_new ? result : (load_pend ? pend_q : data_q);
        pend_d      = store_pend ? result : pend_q;
        pend_full_d = store_pend || (pend_full_q && !lo_exit);

        if (state_q == IDLE) begin
            if (load_new) begin
                state_d = SHOW_HI;
            end
        end else begin
            presc_d = tick ? 16'd0 : presc_q + 16'd1;
            dwell_d = dwell_q;
            if (tick) begin
                dwell_d = phase_end ? 8'd0 : dwell_q + 8'd1;
            end
            if (phase_end) begin
                unique case (state_q)
                    SHOW_HI: state_d = GAP_HI;
                    GAP_HI:  state_d = SHOW_LO;
                    SHOW_LO: state_d = GAP_LO;
                    GAP_LO:  state_d = (load_new || load_pend) ? SHOW_HI : IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end

        // Outputs are decoded from the next state so the registered glyph
        // appears in the same cycle the FSM enters the phase.
        show_d   = (state_d == SHOW_HI) || (state_d == SHOW_LO);
        nibble_d = (state_d == SHOW_HI) ? data_d[7:4] : data_d[3:0];
        unique case (state_d)
            IDLE:             seg_d = SEG_DASH;
            SHOW_HI, SHOW_LO: seg_d = glyph_d;
            default:          seg_d = SEG_BLANK;
        endcase
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble_i (nibble_d),
        .seg_o    (glyph_d)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            presc_q     <= 16'd0;
            dwell_q     <= 8'd0;
            pend_full_q <= 1'b0;
            seg_q       <= SEG_DASH;
        end else if (ena) begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            dwell_q     <= dwell_d;
            pend_full_q <= pend_full_d;
            seg_q       <= seg_d;
        end
    end

    // NOTE: data payload registers carry no reset; their contents are only
    // observed after a strobe has written them, as qualified by state and
    // pend_full_q.
    always_ff @(posedge clk) begin
        if (ena) begin
            data_q <= data_d;
            pend_q <= pend_d;
        end
    end

`ifdef DISP_CARRY_EN
    logic carry_q, pend_carry_q, dp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q      <= 1'b0;
            pend_carry_q <= 1'b0;
            dp_q         <= 1'b0;
        end else if (ena) begin
            if (load_new) begin
                carry_q <= carry;
            end else if (load_pend) begin
                carry_q <= pend_carry_q;
            end
            if (store_pend) begin
                pend_carry_q <= carry;
            end
            dp_q <= show_d && (load_new ? carry : (load_pend ? pend_carry_q : carry_q));
        end
    end

    assign dp_out = dp_q;
`else
    logic unused_carry;
    logic unused_show;
    assign unused_carry = carry;
    assign unused_show  = show_d;
    assign dp_out       = 1'b0;
`endif

    assign seg_out = seg_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_alu_result_display.sv
// ---------------------------------------------------------------------------
// tb_alu_result_display
//   Directed bench for alu_result_display with PRESCALE=2, DWELL=2, so each
//   display phase lasts 4 clk cycles. Inputs are driven and outputs sampled
//   on the falling edge.
// ---------------------------------------------------------------------------
module tb_alu_result_display;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] result;
    logic       result_valid;
    logic       carry;
    logic [6:0] seg_out;
    logic       dp_out;
    logic       busy;

    int n_checks;
    int n_errors;

`ifdef DISP_CARRY_EN
    localparam logic DP_ON = 1'b1;
`else
    localparam logic DP_ON = 1'b0;
`endif

    alu_result_display #(
        .PRESCALE (2),
        .DWELL    (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .result       (result),
        .result_valid (result_valid),
        .carry        (carry),
        .seg_out      (seg_out),
        .dp_out       (dp_out),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h, expected %02h", tag, obs, exp);
        end
    endtask

    // Checks seg/dp/busy for n consecutive cycles starting at the current
    // falling edge; returns on the falling edge after the last one.
    task automatic expect_run(input string tag, input logic [6:0] seg,
                              input logic dp, input logic bsy, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_seg"}, {1'b0, seg_out}, {1'b0, seg});
            check({tag, "_dp"}, {7'd0, dp_out}, {7'd0, dp});
            check({tag, "_busy"}, {7'd0, busy}, {7'd0, bsy});
            @(negedge clk);
        end
    endtask

    task automatic strobe(input logic [7:0] val, input logic cy);
        result       = val;
        carry        = cy;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        carry        = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        ena          = 1'b1;
        result       = 8'h00;
        result_valid = 1'b0;
        carry        = 1'b0;

        repeat (2) @(negedge clk);
        expect_run("reset", 7'h40, 1'b0, 1'b0, 1);

        // First edge after release only arms; the second captures A5.
        rst_n        = 1'b1;
        result       = 8'hA5;
        result_valid = 1'b1;
        @(negedge clk);
        expect_run("arm_edge1", 7'h40, 1'b0, 1'b0, 1);
        result_valid = 1'b0;

        // Basic sequence: 77 x4, blank x4, 6D x4, blank x4, dash.
        expect_run("a5_hi", 7'h77, 1'b0, 1'b1, 4);
        expect_run("a5_gap_hi", 7'h00, 1'b0, 1'b1, 4);
        expect_run("a5_lo", 7'h6D, 1'b0, 1'b1, 4);
        expect_run("a5_gap_lo", 7'h00, 1'b0, 1'b1, 4);
        expect_run("a5_idle", 7'h40, 1'b0, 1'b0, 2);

        // Pending buffer: 12 displayed, 34 overwritten by 56, 56 follows.
        strobe(8'h12, 1'b0);
        check("p12_first", {1'b0, seg_out}, 8'h06);
        strobe(8'h34, 1'b0);
        strobe(8'h56, 1'b0);
        expect_run("p12_hi", 7'h06, 1'b0, 1'b1, 2);
        expect_run("p12_gap_hi", 7'h00, 1'b0, 1'b1, 4);
        expect_run("p12_lo", 7'h5B, 1'b0, 1'b1, 4);
        expect_run("p12_gap_lo", 7'h00, 1'b0, 1'b1, 4);
        expect_run("p56_hi", 7'h6D, 1'b0, 1'b1, 4);
        expect_run("p56_gap_hi", 7'h00, 1'b0, 1'b1, 4);
        expect_run("p56_lo", 7'h7D, 1'b0, 1'b1, 4);
        expect_run("p56_gap_lo", 7'h00, 1'b0, 1'b1, 4);
        expect_run("p56_idle", 7'h40, 1'b0, 1'b0, 1);

        // Carry on dp, then a pending 22 superseded by a coincident FF.
        strobe(8'h00, 1'b1);
        expect_run("z_hi", 7'h3F, DP_ON, 1'b1, 4);
        expect_run("z_gap_hi", 7'h00, 1'b0, 1'b1, 4);
        check("z_lo_first", {1'b0, seg_out}, 8'h3F);
        strobe(8'h22, 1'b0);
        expect_run("z_lo", 7'h3F, DP_ON, 1'b1, 3);
        expect_run("z_gap_lo", 7'h00, 1'b0, 1'b1, 3);
        check("z_gap_lo_last", {1'b0, seg_out}, 8'h00);
        strobe(8'hFF, 1'b0);
        expect_run("ff_hi", 7'h71, 1'b0, 1'b1, 4);
        expect_run("ff_gap_hi", 7'h00, 1'b0, 1'b1, 4);
        expect_run("ff_lo", 7'h71, 1'b0, 1'b1, 4);
        expect_run("ff_gap_lo", 7'h00, 1'b0, 1'b1, 4);
        expect_run("ff_idle", 7'h40, 1'b0, 1'b0, 1);

        // ena freeze in GAP_HI: 4 enabled + 7 frozen cycles, strobe ignored.
        strobe(8'h81, 1'b0);
        expect_run("f81_hi", 7'h7F, 1'b0, 1'b1, 4);
        for (int i = 1; i <= 11; i++) begin
            check("f81_gap_hi_seg", {1'b0, seg_out}, 8'h00);
            check("f81_gap_hi_busy", {7'd0, busy}, 8'h01);
            if (i == 3) begin
                ena          = 1'b0;
                result       = 8'hEE;
                result_valid = 1'b1;
            end
            if (i == 10) begin
                ena          = 1'b1;
                result_valid = 1'b0;
            end
            @(negedge clk);
        end
        expect_run("f81_lo", 7'h06, 1'b0, 1'b1, 4);
        expect_run("f81_gap_lo", 7'h00, 1'b0, 1'b1, 4);
        expect_run("f81_idle", 7'h40, 1'b0, 1'b0, 2);

        // Asynchronous reset mid-SHOW_LO, sampled between clock edges.
        strobe(8'h5A, 1'b0);
        expect_run("r5a_hi", 7'h6D, 1'b0, 1'b1, 4);
        expect_run("r5a_gap_hi", 7'h00, 1'b0, 1'b1, 4);
        expect_run("r5a_lo", 7'h77, 1'b0, 1'b1, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_seg", {1'b0, seg_out}, 8'h40);
        check("rst_async_busy", {7'd0, busy}, 8'h00);
        check("rst_async_dp", {7'd0, dp_out}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        expect_run("rst_after", 7'h40, 1'b0, 1'b0, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
